bram_read_arbiter: RTL

- Shares the single read port of the word-addressed BRAM between NUM_REQ requesters.
- Each requester asks for a burst of consecutive 32-bit words, given as a start word offset and a length.
- The block arbitrates round-robin, sequences the BRAM enable/address per word and absorbs the BRAM's 1-cycle registered read latency.
- Each word is returned on a shared valid/ready response stream tagged with the requester id.

---
 rtl/bram_read_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/bram_read_arbiter.sv
// Round-robin arbiter sharing one registered-read BRAM port among NUM_REQ burst
// requesters; returns each word on a tagged valid/ready response stream.
module bram_read_arbiter #(
    parameter int unsigned NUM_REQ   = 2,
    parameter logic [31:0] BASE_ADDR = 32'hB000_0000,
    parameter int unsigned OFFSET_W  = 16,
    parameter int unsigned LEN_W     = 8,
    localparam int unsigned ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*OFFSET_W-1:0]  req_offset,
    input  logic [NUM_REQ*LEN_W-1:0]     req_len,
    output logic [31:0]                  bram_address,
    output logic                         bram_enable,
    input  logic [31:0]                  bram_data_in,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [31:0]                  rsp_data,
    output logic [ID_W-1:0]              rsp_id,
    output logic                         rsp_last,
    output logic                         busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, LATCH, RESP} state_t;

    state_t              state, state_next;
    logic [ID_W-1:0]     rr_last, grant_id, id_q;
    logic                grant_any;
    logic [OFFSET_W-1:0] grant_off, off_q, word_idx;
    logic [LEN_W-1:0]    grant_len, len_q, beat;

    // First pending requester after the last one served, wrapping around.
    always_comb begin
        int unsigned cand;
        cand      = 0;
        grant_any = 1'b0;
        grant_id  = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = (32'(rr_last) + k) % NUM_REQ;
            if (!grant_any && req_valid[cand]) begin
                grant_any = 1'b1;
                grant_id  = ID_W'(cand);
            end
        end
    end

    assign grant_off = req_offset[32'(grant_id)*OFFSET_W +: OFFSET_W];
    assign grant_len = req_len[32'(grant_id)*LEN_W +: LEN_W];

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next  = state;
        req_ready   = '0;
        bram_enable = 1'b0;
        case (state)
            IDLE: begin
                if (grant_any && !reset) begin
                    req_ready[grant_id] = 1'b1;
                    if (grant_len != '0) state_next = ISSUE;
                end
            end
            ISSUE: begin
                bram_enable = 1'b1;
                state_next  = LATCH;
            end
            LATCH: state_next = RESP;
            RESP: begin
                if (rsp_ready) state_next = rsp_last ? IDLE : ISSUE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Word index wraps within the offset width before being scaled to bytes.
    assign word_idx     = off_q + OFFSET_W'(beat);
    assign bram_address = (state == ISSUE || state == LATCH) ?
                          BASE_ADDR + (32'(word_idx) << 2) : '0;
    assign rsp_valid    = (state == RESP);
    assign busy         = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_last  <= ID_W'(NUM_REQ - 1);
            beat     <= '0;
            off_q    <= '0;
            len_q    <= '0;
            id_q     <= '0;
            rsp_data <= '0;
            rsp_last <= 1'b0;
            rsp_id   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        rr_last <= grant_id;
                        beat    <= '0;
                        off_q   <= grant_off;
                        len_q   <= grant_len;
                        id_q    <= grant_id;
                    end
                end
                LATCH: begin
                    rsp_data <= bram_data_in;
                    rsp_last <= (beat == len_q - LEN_W'(1));
                    rsp_id   <= id_q;
                end
                RESP: begin
                    if (rsp_ready && !rsp_last) beat <= beat + LEN_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
